// File: rtl/axis_pattern_gen.sv
// rtl/axis_pattern_gen.sv - AXI4-Stream master pattern/traffic generator
//
// Ports:
//   m00_axis_aclk / m00_axis_aresetn : clock, asynchronous active-low reset
//   start, stop                      : run control pulses
//   mode, const_word, pkt_len,
//   num_pkts, gap_cycles, stall_en   : run configuration, sampled on start
//   m00_axis_t*                      : AXI4-Stream master interface
//   busy, done                       : run status (done pulses on entry to DONE)
//   pkt_count, beat_count            : completed packets / accepted beats in this run
module axis_pattern_gen #(
    parameter int          TDATA_WIDTH = 32,
    parameter int          LEN_WIDTH   = 16,
    parameter int          GAP_WIDTH   = 8,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468
) (
    input  logic                     m00_axis_aclk,
    input  logic                     m00_axis_aresetn,
    input  logic                     start,
    input  logic                     stop,
    input  logic [1:0]               mode,
    input  logic [31:0]              const_word,
    input  logic [LEN_WIDTH-1:0]     pkt_len,
    input  logic [LEN_WIDTH-1:0]     num_pkts,
    input  logic [GAP_WIDTH-1:0]     gap_cycles,
    input  logic                     stall_en,
    output logic                     m00_axis_tvalid,
    output logic [TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                     m00_axis_tlast,
    input  logic                     m00_axis_tready,
    output logic                     busy,
    output logic                     done,
    output logic [LEN_WIDTH-1:0]     pkt_count,
    output logic [31:0]              beat_count
);

    localparam int          LANES = TDATA_WIDTH / 32;
    // An all-zero state would lock the LFSR up, so a zero seed is replaced by 1.
    localparam logic [31:0] SEED  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] TAPS  = 32'h8020_0003;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] M_CNT   = 2'd0;
    localparam logic [1:0] M_LFSR  = 2'd1;
    localparam logic [1:0] M_CONST = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             r_mode;
    logic [31:0]            r_const;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_num;
    logic [LEN_WIDTH-1:0]   r_beat_idx;
    logic [LEN_WIDTH-1:0]   r_pkt_count;
    logic [GAP_WIDTH-1:0]   r_gap;
    logic [GAP_WIDTH-1:0]   r_gap_cnt;
    logic                   r_stall_en;
    logic                   r_stop_pend;
    logic                   r_tvalid;
    logic [31:0]            r_lfsr;
    logic [31:0]            r_beat_count;

    logic                   w_hs;
    logic                   w_last;
    logic                   w_stall;
    logic                   w_stop_any;
    logic                   w_finish;
    logic [LEN_WIDTH-1:0]   w_pkt_inc;
    logic [31:0]            w_lfsr_next;
    logic [31:0]            w_idx;
    logic [TDATA_WIDTH-1:0] w_data;

    assign w_hs        = r_tvalid & m00_axis_tready;
    assign w_last      = (r_beat_idx == r_len - LEN_WIDTH'(1));
    // A stall only withholds the next beat for a single cycle; the cycle after
    // a stall always presents, so a frozen LFSR (LFSR mode) cannot deadlock.
    assign w_stall     = r_stall_en & r_lfsr[0];
    assign w_stop_any  = r_stop_pend | stop;
    assign w_pkt_inc   = r_pkt_count + LEN_WIDTH'(1);
    assign w_finish    = w_stop_any | ((r_num != '0) && (w_pkt_inc == r_num));
    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

    // Lane data is a pure function of registers that only change on a
    // handshake, so it holds stable while a beat waits for tready.
    always_comb begin
        w_data = '0;
        w_idx  = '0;
        for (int l = 0; l < LANES; l++) begin
            w_idx = r_beat_count * LANES + 32'(l);
            case (r_mode)
                M_CNT:   w_data[32*l +: 32] = w_idx;
                M_LFSR:  w_data[32*l +: 32] = r_lfsr ^ 32'(l);
                M_CONST: w_data[32*l +: 32] = r_const;
                default: w_data[32*l +: 32] = 32'd1 << w_idx[4:0];
            endcase
        end
    end

    assign m00_axis_tvalid = r_tvalid;
    assign m00_axis_tdata  = r_tvalid ? w_data : '0;
    assign m00_axis_tstrb  = {(TDATA_WIDTH/8){r_tvalid}};
    assign m00_axis_tlast  = r_tvalid & w_last;
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign pkt_count       = r_pkt_count;
    assign beat_count      = r_beat_count;

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_state      <= S_IDLE;
            r_mode       <= '0;
            r_const      <= '0;
            r_len        <= '0;
            r_num        <= '0;
            r_beat_idx   <= '0;
            r_pkt_count  <= '0;
            r_gap        <= '0;
            r_gap_cnt    <= '0;
            r_stall_en   <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_tvalid     <= 1'b0;
            r_lfsr       <= SEED;
            r_beat_count <= '0;
        end else begin
            // In LFSR mode the LFSR is the data source and steps per beat;
            // otherwise it free-runs to feed stall decisions.
            if (r_state != S_IDLE && (r_mode != M_LFSR || w_hs)) begin
                r_lfsr <= w_lfsr_next;
            end
            if (r_state != S_IDLE && stop) begin
                r_stop_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode       <= mode;
                        r_const      <= const_word;
                        r_len        <= (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
                        r_num        <= num_pkts;
                        r_gap        <= gap_cycles;
                        r_stall_en   <= stall_en;
                        r_stop_pend  <= 1'b0;
                        r_lfsr       <= SEED;
                        r_beat_idx   <= '0;
                        r_pkt_count  <= '0;
                        r_beat_count <= '0;
                        r_tvalid     <= 1'b1;
                        r_state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        r_beat_count <= r_beat_count + 32'd1;
                        if (w_last) begin
                            r_pkt_count <= w_pkt_inc;
                            r_beat_idx  <= '0;
                            if (w_finish) begin
                                r_tvalid <= 1'b0;
                                r_state  <= S_DONE;
                            end else if (r_gap != '0) begin
                                r_tvalid  <= 1'b0;
                                r_gap_cnt <= r_gap;
                                r_state   <= S_GAP;
                            end else begin
                                r_tvalid <= ~w_stall;
                            end
                        end else begin
                            r_beat_idx <= r_beat_idx + LEN_WIDTH'(1);
                            r_tvalid   <= ~w_stall;
                        end
                    end else if (!r_tvalid) begin
                        r_tvalid <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_WIDTH'(1)) begin
                        if (w_stop_any) begin
                            r_state <= S_DONE;
                        end else begin
                            r_tvalid <= ~w_stall;
                            r_state  <= S_SEND;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb/tb_axis_pattern_gen.sv - self-checking bench for axis_pattern_gen
module tb_axis_pattern_gen;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] const_word = 32'd0;
    logic [15:0] pkt_len = 16'd0;
    logic [15:0] num_pkts = 16'd0;
    logic [7:0]  gap_cycles = 8'd0;
    logic        stall_en = 1'b0;
    logic        tready = 1'b0;

    logic         v32, l32, busy32, done32;
    logic [31:0]  d32;
    logic [3:0]   s32;
    logic [15:0]  pc32;
    logic [31:0]  bc32;
    logic         v128, l128, busy128, done128;
    logic [127:0] d128;
    logic [15:0]  s128;
    logic [15:0]  pc128;
    logic [31:0]  bc128;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    axis_pattern_gen #(.TDATA_WIDTH(32)) dut32 (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start), .stop(stop),
        .mode(mode), .const_word(const_word), .pkt_len(pkt_len), .num_pkts(num_pkts),
        .gap_cycles(gap_cycles), .stall_en(stall_en), .m00_axis_tvalid(v32),
        .m00_axis_tdata(d32), .m00_axis_tstrb(s32), .m00_axis_tlast(l32),
        .m00_axis_tready(tready), .busy(busy32), .done(done32), .pkt_count(pc32),
        .beat_count(bc32)
    );

    axis_pattern_gen #(.TDATA_WIDTH(128)) dut128 (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start), .stop(stop),
        .mode(mode), .const_word(const_word), .pkt_len(pkt_len), .num_pkts(num_pkts),
        .gap_cycles(gap_cycles), .stall_en(stall_en), .m00_axis_tvalid(v128),
        .m00_axis_tdata(d128), .m00_axis_tstrb(s128), .m00_axis_tlast(l128),
        .m00_axis_tready(tready), .busy(busy128), .done(done128), .pkt_count(pc128),
        .beat_count(bc128)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference LFSR: multiply the state by x modulo the feedback polynomial.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] poly;
        poly = 32'h8020_0003;
        return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    endfunction

    function automatic logic [31:0] lane_word(input logic [1:0] m, input logic [31:0] cw,
                                              input logic [31:0] lf, input int n,
                                              input int lanes, input int l);
        int unsigned pos;
        pos = n * lanes + l;
        case (m)
            2'd0:    return pos;
            2'd1:    return lf ^ l;
            2'd2:    return cw;
            default: return 32'd1 << (pos % 32);
        endcase
    endfunction

    task automatic run(input string nm, input logic [1:0] m, input logic [31:0] cw,
                       input int len, input int num, input int gap, input logic st,
                       input int rdy, input int stop_at, input int exp_beats);
        int eff_len, beats, cyc, lowcnt, stall_low, extra_v;
        logic in_gap, held, done_seen, last, p_last;
        logic [31:0] lf;
        logic [127:0] e128, p128;
        eff_len = (len == 0) ? 1 : len;
        beats = 0; cyc = 0; lowcnt = 0; stall_low = 0; extra_v = 0;
        in_gap = 1'b0; held = 1'b0; done_seen = 1'b0; last = 1'b0; p_last = 1'b0;
        lf = SEED; e128 = '0; p128 = '0;
        @(negedge clk);
        mode = m; const_word = cw; pkt_len = 16'(len); num_pkts = 16'(num);
        gap_cycles = 8'(gap); stall_en = st; tready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, " busy"}, 128'(busy32), 128'(1));
        while (!done_seen && cyc < 2000) begin
            cyc++;
            stop = 1'b0;
            if (done32) begin
                done_seen = 1'b1;
            end else begin
                case (rdy)
                    0:       tready = 1'b1;
                    1:       tready = (cyc % 4 == 1) || (cyc % 4 == 0);
                    default: tready = 1'($urandom_range(0, 1));
                endcase
                if (v32) begin
                    if (held) begin
                        chk({nm, " held data"}, d128, p128);
                        chk({nm, " held last"}, 128'(l32), 128'(p_last));
                    end
                    if (in_gap && !st) chk({nm, " gap len"}, 128'(lowcnt), 128'(gap));
                    in_gap = 1'b0;
                    if (tready) begin
                        for (int l = 0; l < 4; l++) e128[32*l +: 32] = lane_word(m, cw, lf, beats, 4, l);
                        last = ((beats % eff_len) == eff_len - 1);
                        chk({nm, " data32"}, 128'(d32), 128'(lane_word(m, cw, lf, beats, 1, 0)));
                        chk({nm, " data128"}, d128, e128);
                        chk({nm, " tlast32"}, 128'(l32), 128'(last));
                        chk({nm, " tlast128"}, 128'(l128), 128'(last));
                        chk({nm, " tstrb"}, {s128, s32}, 128'(20'hFFFFF));
                        if (m == 2'd1) lf = lfsr_step(lf);
                        if (beats == stop_at) stop = 1'b1;
                        beats++;
                        if (last) begin
                            in_gap = 1'b1;
                            lowcnt = 0;
                        end
                        held = 1'b0;
                    end else begin
                        held = 1'b1;
                        p128 = d128;
                        p_last = l32;
                    end
                end else begin
                    held = 1'b0;
                    if (in_gap) lowcnt++;
                    else stall_low++;
                end
                @(negedge clk);
            end
        end
        stop = 1'b0;
        chk({nm, " done seen"}, 128'(done_seen), 128'(1));
        chk({nm, " done latency"}, 128'(lowcnt), 128'(0));
        chk({nm, " busy in done"}, 128'(busy32), 128'(1));
        chk({nm, " beats"}, 128'(beats), 128'(exp_beats));
        chk({nm, " pkt_count"}, {pc128, pc32}, {16'(exp_beats / eff_len), 16'(exp_beats / eff_len)});
        chk({nm, " beat_count"}, {bc128, bc32}, {32'(exp_beats), 32'(exp_beats)});
        if (st && rdy == 0) chk({nm, " stall gaps"}, 128'(stall_low > 0), 128'(1));
        @(negedge clk);
        chk({nm, " idle busy/done"}, {busy32, done32, busy128, done128}, 128'(0));
        repeat (3) begin
            if (v32 || v128) extra_v++;
            @(negedge clk);
        end
        chk({nm, " no extra beats"}, 128'(extra_v), 128'(0));
    endtask

    initial begin
        int rl, rn, rg;
        logic [1:0] rm;
        repeat (2) @(negedge clk);
        chk("reset tvalid/tlast", {v32, l32, v128, l128}, 128'(0));
        chk("reset tdata", {d128, d32}, 128'(0));
        chk("reset tstrb", {s128, s32}, 128'(0));
        chk("reset status", {busy32, done32, pc32, bc32}, 128'(0));
        rst_n = 1'b1;

        run("cnt basic",   2'd0, 32'd0, 4, 2, 0, 1'b0, 0, -1, 8);
        run("backpress",   2'd0, 32'd0, 5, 3, 0, 1'b0, 1, -1, 15);
        run("gap3",        2'd0, 32'd0, 2, 3, 3, 1'b0, 0, -1, 6);
        run("stop mid",    2'd0, 32'd0, 8, 0, 0, 1'b0, 0, 2, 8);
        run("stall",       2'd0, 32'd0, 4, 4, 0, 1'b1, 0, -1, 16);
        run("lfsr",        2'd1, 32'd0, 3, 2, 0, 1'b0, 2, -1, 6);
        run("const",       2'd2, $urandom, 1, 4, 1, 1'b0, 2, -1, 4);
        run("walk",        2'd3, 32'd0, 20, 2, 0, 1'b0, 2, -1, 40);
        run("len0",        2'd0, 32'd0, 0, 3, 0, 1'b0, 0, -1, 3);

        for (int i = 0; i < 4; i++) begin
            rm = 2'($urandom_range(0, 3));
            rl = int'($urandom_range(1, 6));
            rn = int'($urandom_range(1, 4));
            rg = int'($urandom_range(0, 3));
            run("random", rm, $urandom, rl, rn, rg, 1'($urandom_range(0, 1)), 2, -1, rl * rn);
        end

        // Asynchronous reset in the middle of an unbounded run.
        @(negedge clk);
        mode = 2'd0; pkt_len = 16'd8; num_pkts = 16'd0; gap_cycles = 8'd0;
        stall_en = 1'b0; tready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre-reset tvalid", 128'(v32), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async reset drop", {v32, l32, busy32, v128, l128, busy128}, 128'(0));
        chk("async reset counts", {bc32, pc32}, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run("after reset", 2'd0, 32'd0, 3, 2, 1, 1'b0, 0, -1, 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
